// File: rtl/rv32_regfile_dbg.sv
// Debug initiator for the rv32 register file: host read/write/dump requests, core halt handshake, regfile port drive.
// Latency: accept at T, regfile access at T+2, response valid at T+3 (core already halted); 2 cycles per further dump entry.
// Backpressure: req_ready only in IDLE; response fields held stable until resp_ready; a dump advances only on handshake.
//
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   req_valid/req_ready            host request channel (req_op, req_addr, req_wdata)
//                                  req_op: 00 read, 01 write, 10 dump, 11 illegal
//   resp_valid/resp_ready          host response channel (resp_addr, resp_data, resp_last, resp_err)
//   dbg_halt_req, core_halted      core halt request / acknowledge
//   rf_sel                         steers the regfile port muxes to this block
//   rf_ra, rf_rd                   regfile read port (rf_rd is combinational from rf_ra)
//   rf_wen, rf_wa, rf_wd           regfile write port
module rv32_regfile_dbg #(
    parameter int XPR_LEN        = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int NUM_REGS       = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [1:0]                req_op,
    input  logic [REG_ADDR_WIDTH-1:0] req_addr,
    input  logic [XPR_LEN-1:0]        req_wdata,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [REG_ADDR_WIDTH-1:0] resp_addr,
    output logic [XPR_LEN-1:0]        resp_data,
    output logic                      resp_last,
    output logic                      resp_err,
    output logic                      dbg_halt_req,
    input  logic                      core_halted,
    output logic                      rf_sel,
    output logic [REG_ADDR_WIDTH-1:0] rf_ra,
    input  logic [XPR_LEN-1:0]        rf_rd,
    output logic                      rf_wen,
    output logic [REG_ADDR_WIDTH-1:0] rf_wa,
    output logic [XPR_LEN-1:0]        rf_wd
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        HALT_WAIT = 2'd1,
        EXEC      = 2'd2,
        RESP      = 2'd3
    } state_t;

    localparam logic [1:0] OP_RD   = 2'b00;
    localparam logic [1:0] OP_WR   = 2'b01;
    localparam logic [1:0] OP_DUMP = 2'b10;
    localparam logic [1:0] OP_ILL  = 2'b11;

    localparam logic [REG_ADDR_WIDTH-1:0] LAST_IDX = REG_ADDR_WIDTH'(NUM_REGS - 1);
    localparam logic [REG_ADDR_WIDTH-1:0] ADDR_0   = '0;

    state_t                    state;
    logic [1:0]                op_q;
    logic [REG_ADDR_WIDTH-1:0] addr_q;
    logic [XPR_LEN-1:0]        wdata_q;
    logic [REG_ADDR_WIDTH-1:0] cnt_q;

    logic                      in_exec;
    logic                      op_is_wr;
    logic [REG_ADDR_WIDTH-1:0] exec_addr;

    assign in_exec   = (state == EXEC);
    assign op_is_wr  = (op_q == OP_WR);
    // Dump sweeps the counter; read/write use the latched request address.
    assign exec_addr = (op_q == OP_DUMP) ? cnt_q : addr_q;

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);

    // Ports stay ours through RESP so the core cannot resume between dump entries;
    // an illegal op never halts the core, so it never takes the ports.
    assign rf_sel = in_exec || ((state == RESP) && dbg_halt_req);

    assign rf_ra  = (in_exec && !op_is_wr) ? exec_addr : '0;
    // Gated by core_halted: a halt that drops during EXEC must not produce a write.
    assign rf_wen = in_exec && core_halted && op_is_wr && (addr_q != ADDR_0);
    assign rf_wa  = rf_wen ? addr_q  : '0;
    assign rf_wd  = rf_wen ? wdata_q : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            op_q         <= OP_RD;
            addr_q       <= '0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            resp_addr    <= '0;
            resp_data    <= '0;
            resp_last    <= 1'b0;
            resp_err     <= 1'b0;
            dbg_halt_req <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_q    <= req_op;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        cnt_q   <= '0;
                        if (req_op == OP_ILL) begin
                            resp_addr <= req_addr;
                            resp_data <= '0;
                            resp_last <= 1'b1;
                            resp_err  <= 1'b1;
                            state     <= RESP;
                        end else begin
                            resp_err     <= 1'b0;
                            dbg_halt_req <= 1'b1;
                            state        <= HALT_WAIT;
                        end
                    end
                end

                HALT_WAIT: begin
                    if (core_halted) begin
                        state <= EXEC;
                    end
                end

                EXEC: begin
                    if (!core_halted) begin
                        // Core resumed under us: no access, re-wait for the halt.
                        state <= HALT_WAIT;
                    end else begin
                        resp_addr <= exec_addr;
                        resp_err  <= 1'b0;
                        if (exec_addr == ADDR_0) begin
                            resp_data <= '0;
                        end else if (op_is_wr) begin
                            resp_data <= wdata_q;
                        end else begin
                            resp_data <= rf_rd;
                        end
                        resp_last <= (op_q == OP_DUMP) ? (cnt_q == LAST_IDX) : 1'b1;
                        state     <= RESP;
                    end
                end

                RESP: begin
                    if (resp_ready) begin
                        if ((op_q == OP_DUMP) && !resp_last) begin
                            cnt_q <= cnt_q + 1'b1;
                            state <= EXEC;
                        end else begin
                            dbg_halt_req <= 1'b0;
                            state        <= IDLE;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rv32_regfile_dbg.sv
module tb_rv32_regfile_dbg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [4:0]  req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [4:0]  resp_addr;
    logic [31:0] resp_data;
    logic        resp_last;
    logic        resp_err;
    logic        dbg_halt_req;
    logic        core_halted;
    logic        rf_sel;
    logic [4:0]  rf_ra;
    logic [31:0] rf_rd;
    logic        rf_wen;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;

    always #5 clk = ~clk;

    rv32_regfile_dbg #(.XPR_LEN(32), .REG_ADDR_WIDTH(5), .NUM_REGS(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_addr(resp_addr),
        .resp_data(resp_data), .resp_last(resp_last), .resp_err(resp_err),
        .dbg_halt_req(dbg_halt_req), .core_halted(core_halted), .rf_sel(rf_sel),
        .rf_ra(rf_ra), .rf_rd(rf_rd), .rf_wen(rf_wen), .rf_wa(rf_wa), .rf_wd(rf_wd)
    );

    // Regfile model: raw storage, x0 deliberately holds garbage so the DUT must force 0.
    logic [31:0] regs [32];
    assign rf_rd = regs[rf_ra];
    always @(posedge clk) if (rf_wen) regs[rf_wa] <= rf_wd;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
        logic        last;
        logic        err;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compares every presented response against the scoreboard head,
    // including stalled cycles, and pops on handshake.
    always @(negedge clk) begin
        if (rst_n && resp_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_resp", 64'(resp_addr), 64'h0);
            end else begin
                mon_e = sb[0];
                if (resp_ready) begin
                    check("resp_addr", 64'(resp_addr), 64'(mon_e.addr));
                    check("resp_data", 64'(resp_data), 64'(mon_e.data));
                    check("resp_last", 64'(resp_last), 64'(mon_e.last));
                    check("resp_err",  64'(resp_err),  64'(mon_e.err));
                    void'(sb.pop_front());
                end else begin
                    check("stall_hold", 64'({resp_addr, resp_data, resp_last}),
                          64'({mon_e.addr, mon_e.data, mon_e.last}));
                end
            end
        end
    end

    // Port watcher: write pulses, halt cycles, and write port driven only with rf_wen.
    int          wen_cnt = 0;
    int          halt_cnt = 0;
    int          idle_drive_viol = 0;
    logic [4:0]  last_wa = '0;
    logic [31:0] last_wd = '0;
    always @(negedge clk) begin
        if (rf_wen) begin
            wen_cnt++;
            last_wa = rf_wa;
            last_wd = rf_wd;
        end else if (rf_wa != 5'd0 || rf_wd != 32'd0) begin
            idle_drive_viol++;
        end
        if (dbg_halt_req) halt_cnt++;
    end

    // Response backpressure driver.
    bit bp_en = 1'b0;
    initial begin
        resp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            resp_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic issue(input logic [1:0] op, input logic [4:0] addr, input logic [31:0] wd);
        bit rdy;
        int t;
        t = 0;
        @(posedge clk);
        #1;
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
        do begin
            @(negedge clk);
            rdy = req_ready;
            @(posedge clk);
            t++;
        end while (!rdy && t < 100);
        if (!rdy) check("req_accept_timeout", 64'h0, 64'h1);
        #1;
        req_valid = 1'b0; req_op = 2'b00; req_addr = '0; req_wdata = '0;
    endtask

    task automatic wait_resp_edges(output int n);
        n = 0;
        while (!resp_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic drain(input int budget);
        int t;
        t = 0;
        while (sb.size() != 0 && t < budget) begin
            @(posedge clk);
            t++;
        end
        if (sb.size() != 0) check("drain_timeout", 64'(sb.size()), 64'h0);
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [4:0] a, input logic [31:0] d, input logic l, input logic e);
        exp_t x;
        x.addr = a; x.data = d; x.last = l; x.err = e;
        sb.push_back(x);
    endtask

    initial begin
        int n, w0, h0, bad, t;
        rst_n = 1'b1; req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0;
        core_halted = 1'b1;
        for (int i = 0; i < 32; i++) regs[i] = 32'hA500_0000 | i;
        regs[5] = 32'hDEAD_BEEF;
        #1 rst_n = 1'b0;
        #1;
        check("reset_ctrl", 64'({req_ready, resp_valid, dbg_halt_req, rf_sel, rf_wen, resp_last, resp_err}), 64'b1000000);
        check("reset_data", 64'({resp_addr, resp_data, rf_ra}), 64'h0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Read x5 with core already halted: response 2 edges after the accept edge (T+3).
        push(5'd5, 32'hDEAD_BEEF, 1'b1, 1'b0);
        issue(2'b00, 5'd5, 32'h0);
        wait_resp_edges(n);
        check("read_latency", 64'(n), 64'd2);
        drain(50);

        // Write x7, then read it back.
        w0 = wen_cnt;
        push(5'd7, 32'h1234_5678, 1'b1, 1'b0);
        issue(2'b01, 5'd7, 32'h1234_5678);
        drain(50);
        check("wr_pulse_cnt", 64'(wen_cnt - w0), 64'd1);
        check("wr_addr", 64'(last_wa), 64'd7);
        check("wr_data", 64'(last_wd), 64'h1234_5678);
        push(5'd7, 32'h1234_5678, 1'b1, 1'b0);
        issue(2'b00, 5'd7, 32'h0);
        drain(50);

        // Write x0: no write strobe, response data 0; reading x0 returns 0 despite garbage.
        w0 = wen_cnt;
        push(5'd0, 32'h0, 1'b1, 1'b0);
        issue(2'b01, 5'd0, 32'hFFFF_FFFF);
        drain(50);
        check("wr_x0_no_wen", 64'(wen_cnt - w0), 64'd0);
        push(5'd0, 32'h0, 1'b1, 1'b0);
        issue(2'b00, 5'd0, 32'h0);
        drain(50);

        // Core not halted for 20 cycles: halt requested, nothing else happens.
        core_halted = 1'b0;
        push(5'd9, 32'hA500_0009, 1'b1, 1'b0);
        issue(2'b00, 5'd9, 32'h0);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (rf_sel || resp_valid || !dbg_halt_req) bad++;
        end
        check("halt_wait_quiet", 64'(bad), 64'd0);
        @(posedge clk);
        #1 core_halted = 1'b1;
        wait_resp_edges(n);
        check("halt_resume_latency", 64'(n), 64'd2);
        drain(50);

        // Illegal op: error response, never a halt request.
        h0 = halt_cnt;
        push(5'd3, 32'h0, 1'b1, 1'b1);
        issue(2'b11, 5'd3, 32'h55);
        drain(50);
        check("illegal_no_halt", 64'(halt_cnt - h0), 64'd0);

        // Full dump with random backpressure.
        for (int i = 0; i < 32; i++) regs[i] = 32'(i * 3);
        regs[0] = 32'hBAD0_BAD0;
        for (int i = 0; i < 32; i++) push(5'(i), (i == 0) ? 32'h0 : 32'(i * 3), i == 31, 1'b0);
        bp_en = 1'b1;
        issue(2'b10, 5'd17, 32'h0);
        drain(2000);
        bp_en = 1'b0;
        @(posedge clk);
        #1;

        // Reset while the dump is presenting x10.
        for (int i = 0; i < 32; i++) push(5'(i), (i == 0) ? 32'h0 : 32'(i * 3), i == 31, 1'b0);
        issue(2'b10, 5'd0, 32'h0);
        t = 0;
        while (!(resp_valid && resp_addr == 5'd10) && t < 500) begin
            @(posedge clk);
            #2;
            t++;
        end
        check("dump_reach_x10", 64'(resp_addr), 64'd10);
        w0 = wen_cnt;
        rst_n = 1'b0;
        #1;
        check("midreset_ctrl", 64'({req_ready, resp_valid, dbg_halt_req, rf_sel, rf_wen, resp_last, resp_err}), 64'b1000000);
        check("midreset_data", 64'({resp_addr, resp_data, rf_ra}), 64'h0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("req_ready_after_reset", 64'(req_ready), 64'd1);
        check("midreset_no_write", 64'(wen_cnt - w0), 64'd0);

        // Block still works after the reset.
        push(5'd4, 32'd12, 1'b1, 1'b0);
        issue(2'b00, 5'd4, 32'h0);
        drain(50);

        check("wport_idle_zero", 64'(idle_drive_viol), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
